// File: rtl/sb_pkg.sv
// Shared types and sizing for the store buffer: entry layout and default geometry.
package sb_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_PW    = $clog2(SB_DEPTH);
    localparam int SB_AW    = 32;
    localparam int SB_DW    = 32;

    // Word-granular entry; the byte offset is dropped at capture time.
    typedef struct packed {
        logic [SB_AW-1:2] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

    function automatic logic [SB_AW-1:0] sb_byte_addr(input logic [SB_AW-1:2] word);
        return {word, 2'b00};
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Processor store/load-check side and memory drain side of the store buffer.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;

    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;

    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    // master = processor plus memory environment, slave = the buffer itself
    modport master (
        output memwrite, dataadr, writedata, ld_addr, mem_ready,
        input  stall, ld_hit, ld_data, mem_valid, mem_addr, mem_data
    );

    modport slave (
        input  memwrite, dataadr, writedata, ld_addr, mem_ready,
        output stall, ld_hit, ld_data, mem_valid, mem_addr, mem_data
    );

endinterface

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: scans occupied entries oldest to youngest from rd_ptr
// so the last hit in the scan is the most recently pushed matching store.
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [AW-1:0]                ld_addr,
    output logic                         ld_hit,
    output logic [DW-1:0]                ld_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;
    logic [1:0]    unused_lsb;

    assign unused_lsb = ld_addr[1:0];

    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && (entries[idx].addr == ld_addr[AW-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the processor store port and data memory, with
// stall on full and youngest-entry load forwarding.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    store_buffer_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = (DEPTH == SB_DEPTH) ? SB_PW : $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;
    logic [1:0]       unused_lsb;

    assign unused_lsb = bus.dataadr[1:0];

    assign count = occ;
    assign empty = (occ == '0);
    assign full  = (occ == CW'(DEPTH));

    // A pop does not free a slot for a same-cycle push; full always stalls.
    assign push      = bus.memwrite & ~full;
    assign bus.stall = bus.memwrite & full;

    assign bus.mem_valid = ~empty;
    assign pop           = bus.mem_valid & bus.mem_ready;
    assign bus.mem_addr  = sb_byte_addr(entries[rd_ptr].addr);
    assign bus.mem_data  = entries[rd_ptr].data;

    // Payload storage needs no reset; occupancy is tracked by valid/occ.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= '{addr: bus.dataadr[AW-1:2], data: bus.writedata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .entries (entries),
        .valid   (valid),
        .rd_ptr  (rd_ptr),
        .ld_addr (bus.ld_addr),
        .ld_hit  (bus.ld_hit),
        .ld_data (bus.ld_data)
    );

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus a randomized run, all checked
// against a queue-based model of the buffer contents.
module tb_store_buffer;
    import sb_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] count;
    logic       empty;
    logic       full;

    store_buffer_if #(.AW(32), .DW(32)) bus ();

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Model: contents in push order, oldest at index 0.
    logic [29:0] qa[$];
    logic [31:0] qd[$];

    function automatic logic fwd_hit(input logic [31:0] a);
        for (int i = qa.size() - 1; i >= 0; i--)
            if (qa[i] == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] fwd_data(input logic [31:0] a);
        for (int i = qa.size() - 1; i >= 0; i--)
            if (qa[i] == a[31:2]) return qd[i];
        return 32'd0;
    endfunction

    // Advance one clock edge and apply the buffer's rules to the model.
    task automatic tick();
        bit do_pop, do_push;
        @(posedge clk);
        if (reset) begin
            do_pop  = bus.mem_ready && (qa.size() > 0);
            do_push = bus.memwrite && (qa.size() < 4);
            if (do_pop) begin
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (do_push) begin
                qa.push_back(bus.dataadr[31:2]);
                qd.push_back(bus.writedata);
            end
        end
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite  = 1'b1;
        bus.dataadr   = a;
        bus.writedata = d;
        tick();
        bus.memwrite  = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.memwrite  = 1'b1;
        bus.dataadr   = 32'd84;
        bus.writedata = 32'd55;
        bus.ld_addr   = 32'd84;
        bus.mem_ready = 1'b0;
        #12;
        vectors++; if (empty !== 1'b1) begin errs++; $display("FAIL rst_empty got %0b want 1", empty); end
        vectors++; if (count !== 3'd0) begin errs++; $display("FAIL rst_count got %0d want 0", count); end
        vectors++; if (bus.mem_valid !== 1'b0) begin errs++; $display("FAIL rst_mem_valid got %0b want 0", bus.mem_valid); end
        vectors++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL rst_stall got %0b want 0", bus.stall); end
        vectors++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 32'd0) begin errs++; $display("FAIL rst_ld got %0b/%0d want 0/0", bus.ld_hit, bus.ld_data); end
        vectors++; if (full !== 1'b0) begin errs++; $display("FAIL rst_full got %0b want 0", full); end
        #10;
        reset        = 1'b1;
        bus.memwrite = 1'b0;
        tick();
        vectors++; if (count !== 3'd0 || empty !== 1'b1) begin errs++; $display("FAIL rst_release count %0d empty %0b want 0/1", count, empty); end
    endtask

    task automatic test_single();
        bus.mem_ready = 1'b1;
        store(32'd84, 32'd7);
        vectors++; if (bus.mem_valid !== 1'b1) begin errs++; $display("FAIL single_valid got %0b want 1", bus.mem_valid); end
        vectors++; if (bus.mem_addr !== 32'd84) begin errs++; $display("FAIL single_addr got %0d want 84", bus.mem_addr); end
        vectors++; if (bus.mem_data !== 32'd7) begin errs++; $display("FAIL single_data got %0d want 7", bus.mem_data); end
        tick();
        vectors++; if (empty !== 1'b1 || bus.mem_valid !== 1'b0) begin errs++; $display("FAIL single_drain empty %0b valid %0b want 1/0", empty, bus.mem_valid); end
    endtask

    task automatic test_fill_drain();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'd80 + 32'(4 * i), 32'(i + 1));
        vectors++; if (full !== 1'b1 || count !== 3'd4) begin errs++; $display("FAIL fill_full full %0b count %0d want 1/4", full, count); end
        bus.memwrite  = 1'b1;
        bus.dataadr   = 32'd96;
        bus.writedata = 32'd5;
        #1;
        vectors++; if (bus.stall !== 1'b1) begin errs++; $display("FAIL fill_stall got %0b want 1", bus.stall); end
        tick();
        bus.memwrite = 1'b0;
        #1;
        vectors++; if (count !== 3'd4 || bus.mem_addr !== 32'd80) begin errs++; $display("FAIL fill_hold count %0d addr %0d want 4/80", count, bus.mem_addr); end
        vectors++; if (bus.stall !== 1'b0) begin errs++; $display("FAIL fill_stall_drop got %0b want 0", bus.stall); end
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.mem_addr !== 32'd80 + 32'(4 * i) || bus.mem_data !== 32'(i + 1) || bus.mem_valid !== 1'b1) begin
                errs++; $display("FAIL drain_%0d addr %0d data %0d want %0d/%0d", i, bus.mem_addr, bus.mem_data, 80 + 4 * i, i + 1);
            end
            tick();
        end
        vectors++; if (count !== 3'd0 || qa.size() != 0) begin errs++; $display("FAIL drain_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        bus.mem_ready = 1'b0;
        store(32'd200, 32'hA0);
        store(32'd204, 32'hA1);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            d = $urandom;
            bus.memwrite  = 1'b1;
            bus.dataadr   = 32'd208 + 32'(4 * i);
            bus.writedata = d;
            #1;
            vectors++;
            if (count !== 3'd2 || bus.mem_addr !== {qa[0], 2'b00} || bus.mem_data !== qd[0] || bus.stall !== 1'b0) begin
                errs++; $display("FAIL b2b_%0d count %0d addr %0d data %h want 2/%0d/%h", i, count, bus.mem_addr, bus.mem_data, {qa[0], 2'b00}, qd[0]);
            end
            tick();
        end
        bus.memwrite = 1'b0;
        tick(); tick();
        vectors++; if (empty !== 1'b1) begin errs++; $display("FAIL b2b_empty got %0b want 1", empty); end
    endtask

    task automatic test_forward();
        bus.mem_ready = 1'b0;
        store(32'd80, 32'd5);
        store(32'd80, 32'd9);
        bus.ld_addr = 32'd80; #1;
        vectors++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd9) begin errs++; $display("FAIL fwd_80 hit %0b data %0d want 1/9", bus.ld_hit, bus.ld_data); end
        bus.ld_addr = 32'd83; #1;
        vectors++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd9) begin errs++; $display("FAIL fwd_83 hit %0b data %0d want 1/9", bus.ld_hit, bus.ld_data); end
        bus.ld_addr = 32'd88; #1;
        vectors++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 32'd0) begin errs++; $display("FAIL fwd_88 hit %0b data %0d want 0/0", bus.ld_hit, bus.ld_data); end
        bus.memwrite  = 1'b1;
        bus.dataadr   = 32'd88;
        bus.writedata = 32'd3;
        #1;
        vectors++; if (bus.ld_hit !== 1'b0) begin errs++; $display("FAIL fwd_same_cycle_push hit %0b want 0", bus.ld_hit); end
        tick();
        bus.memwrite = 1'b0;
        #1;
        vectors++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 32'd3) begin errs++; $display("FAIL fwd_next_cycle hit %0b data %0d want 1/3", bus.ld_hit, bus.ld_data); end
        bus.ld_addr   = 32'd80;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        vectors++; if (bus.ld_hit !== 1'b0) begin errs++; $display("FAIL fwd_after_pop hit %0b want 0", bus.ld_hit); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bus.mem_ready = 1'b0;
        store(32'd40, 32'd1);
        store(32'd44, 32'd2);
        store(32'd48, 32'd3);
        vectors++; if (count !== 3'd3) begin errs++; $display("FAIL mid_fill count %0d want 3", count); end
        bus.mem_ready = 1'b1;
        #3;
        reset = 1'b0;
        #1;
        qa.delete();
        qd.delete();
        vectors++; if (bus.mem_valid !== 1'b0 || count !== 3'd0) begin errs++; $display("FAIL mid_reset valid %0b count %0d want 0/0", bus.mem_valid, count); end
        #2;
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        store(32'd100, 32'h1234);
        #1;
        vectors++; if (count !== 3'd1 || bus.mem_addr !== 32'd100 || bus.mem_data !== 32'h1234) begin errs++; $display("FAIL mid_after count %0d addr %0d data %h want 1/100/1234", count, bus.mem_addr, bus.mem_data); end
        bus.mem_ready = 1'b1;
        tick();
        vectors++; if (empty !== 1'b1) begin errs++; $display("FAIL mid_only_entry empty %0b want 1", empty); end
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 300; i++) begin
            bus.memwrite  = 1'($urandom_range(0, 99) < 60);
            bus.dataadr   = 32'd64 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
            bus.writedata = $urandom;
            bus.mem_ready = 1'($urandom_range(0, 99) < 45);
            bus.ld_addr   = 32'd64 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
            #1;
            n = qa.size();
            vectors++;
            if (count !== 3'(n) || empty !== (n == 0) || full !== (n == 4) || bus.stall !== (bus.memwrite && n == 4) || bus.mem_valid !== (n > 0)) begin
                errs++; $display("FAIL rnd_ctrl_%0d count %0d stall %0b valid %0b want %0d/%0b/%0b", i, count, bus.stall, bus.mem_valid, n, bus.memwrite && n == 4, n > 0);
            end
            if (n > 0) begin
                vectors++;
                if (bus.mem_addr !== {qa[0], 2'b00} || bus.mem_data !== qd[0]) begin
                    errs++; $display("FAIL rnd_head_%0d addr %0d data %h want %0d/%h", i, bus.mem_addr, bus.mem_data, {qa[0], 2'b00}, qd[0]);
                end
            end
            vectors++;
            if (bus.ld_hit !== fwd_hit(bus.ld_addr) || bus.ld_data !== fwd_data(bus.ld_addr)) begin
                errs++; $display("FAIL rnd_fwd_%0d hit %0b data %h want %0b/%h", i, bus.ld_hit, bus.ld_data, fwd_hit(bus.ld_addr), fwd_data(bus.ld_addr));
            end
            tick();
        end
        bus.memwrite = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_forward();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
